fp64_div_seq: RTL and testbench

// Sequential IEEE-754 binary64 divider (result = A / B), companion to the fp64 multiplier.

---
 rtl/fp64_div_seq.sv | 169 ++++++++++++++++
 tb/tb_fp64_div_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fp64_div_seq.sv
// Sequential IEEE-754 binary64 divider: restoring radix-2 mantissa division,
// one quotient bit per enabled clock, behind a start/busy/done handshake.
module fp64_div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        start,
    input  logic [63:0] A,
    input  logic [63:0] B,
    output logic        busy,
    output logic        done,
    output logic [63:0] result,
    output logic        div_by_zero
);

    localparam int EXP_BIAS = 1023;
    localparam int QBITS    = 55;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DIVIDE, S_NORM} state_t;

    state_t       r_state;
    state_t       w_next;
    logic         r_sign;
    logic [10:0]  r_ea;
    logic [10:0]  r_eb;
    logic [52:0]  r_mb;
    logic [53:0]  r_rem;
    logic [54:0]  r_q;
    logic [5:0]   r_cnt;
    logic [63:0]  r_result;
    logic         r_done;
    logic         r_dbz;

    logic         w_special;
    logic [63:0]  w_spec_res;
    logic         w_spec_dbz;
    logic         w_ge;
    logic [53:0]  w_rem_next;
    logic signed [12:0] w_e_raw;
    logic signed [12:0] w_e_adj;
    logic signed [12:0] w_e_fin;
    logic [51:0]  w_frac;
    logic         w_g;
    logic [52:0]  w_frac_sum;
    logic [63:0]  w_norm_res;

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign result      = r_result;
    assign div_by_zero = r_dbz;

    // Special operands in priority order: NaN/Inf input, 0/0, x/0, 0/x.
    always_comb begin
        w_special  = 1'b1;
        w_spec_dbz = 1'b0;
        w_spec_res = 64'h7FF8000000000000;
        if (r_ea == 11'h7FF || r_eb == 11'h7FF) begin
            w_spec_res = 64'h7FF8000000000000;
        end else if (r_eb == 11'h000 && r_ea == 11'h000) begin
            w_spec_res = 64'h7FF8000000000000;
        end else if (r_eb == 11'h000) begin
            w_spec_res = {r_sign, 11'h7FF, 52'h0};
            w_spec_dbz = 1'b1;
        end else if (r_ea == 11'h000) begin
            w_spec_res = {r_sign, 63'h0};
        end else begin
            w_special  = 1'b0;
        end
    end

    // Partial remainder stays below 2*Mb, so the left shift never overflows 54 bits.
    always_comb begin
        w_ge       = (r_rem >= {1'b0, r_mb});
        w_rem_next = w_ge ? ((r_rem - {1'b0, r_mb}) << 1) : (r_rem << 1);
    end

    always_comb begin
        w_e_raw = $signed({2'b00, r_ea}) - $signed({2'b00, r_eb}) + 13'(EXP_BIAS);
        if (r_q[54]) begin
            w_frac  = r_q[53:2];
            w_g     = r_q[1];
            w_e_adj = w_e_raw;
        end else begin
            w_frac  = r_q[52:1];
            w_g     = r_q[0];
            w_e_adj = w_e_raw - 13'sd1;
        end
        // Round half away from zero; a carry out leaves the fraction at zero.
        w_frac_sum = {1'b0, w_frac} + {52'h0, w_g};
        w_e_fin    = w_frac_sum[52] ? (w_e_adj + 13'sd1) : w_e_adj;
        if (w_e_fin <= 13'sd0) begin
            w_norm_res = {r_sign, 63'h0};
        end else if (w_e_fin >= 13'sd2047) begin
            w_norm_res = {r_sign, 11'h7FF, 52'h0};
        end else begin
            w_norm_res = {r_sign, w_e_fin[10:0], w_frac_sum[51:0]};
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_CHECK;
            S_CHECK:  w_next = w_special ? S_IDLE : S_DIVIDE;
            S_DIVIDE: if (r_cnt == 6'(QBITS - 1)) w_next = S_NORM;
            S_NORM:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (en) begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign   <= 1'b0;
            r_ea     <= '0;
            r_eb     <= '0;
            r_mb     <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else if (en) begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sign <= A[63] ^ B[63];
                        r_ea   <= A[62:52];
                        r_eb   <= B[62:52];
                        r_rem  <= {2'b01, A[51:0]};
                        r_mb   <= {1'b1, B[51:0]};
                        r_q    <= '0;
                        r_cnt  <= '0;
                    end
                end
                S_CHECK: begin
                    r_q   <= '0;
                    r_cnt <= '0;
                    if (w_special) begin
                        r_result <= w_spec_res;
                        r_dbz    <= w_spec_dbz;
                        r_done   <= 1'b1;
                    end
                end
                S_DIVIDE: begin
                    r_q   <= {r_q[53:0], w_ge};
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt + 6'd1;
                end
                S_NORM: begin
                    r_result <= w_norm_res;
                    r_dbz    <= 1'b0;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp64_div_seq.sv
// Directed bench for fp64_div_seq: vector table of divisions with hand-computed
// quotients and latencies, plus reset-abort, start-while-busy and clock-enable sequences.
module tb_fp64_div_seq;

    logic        clk;
    logic        rst;
    logic        en;
    logic        start;
    logic [63:0] A;
    logic [63:0] B;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    fp64_div_seq dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .start       (start),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        dbz;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one division; edge 0 is the edge that samples start.
    task automatic run_div(input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp_res, input logic exp_dbz,
                           input int exp_lat, input logic hold, input int freeze_at,
                           input string name);
        int   n;
        logic busy_ok;
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (hold) begin
            A = 64'h4000000000000000;
            B = 64'h3FF0000000000000;
        end else begin
            start = 1'b0;
        end
        busy_ok = busy;
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (n == freeze_at) en = 1'b0;
            if (n == freeze_at + 10) en = 1'b1;
            if (!done && !busy) busy_ok = 1'b0;
        end
        start = 1'b0;
        chk({name, " latency"}, 64'(n), 64'(exp_lat));
        chk({name, " result"}, result, exp_res);
        chk({name, " div_by_zero"}, 64'(div_by_zero), 64'(exp_dbz));
        chk({name, " busy during op"}, 64'(busy_ok), 64'd1);
        chk({name, " busy after done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int dones;

        vecs[0]  = '{64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 1'b0, 57, "6/2"};
        vecs[1]  = '{64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 1'b0, 57, "1/3"};
        vecs[2]  = '{64'hC020000000000000, 64'h3FE0000000000000, 64'hC030000000000000, 1'b0, 57, "-8/0.5"};
        vecs[3]  = '{64'h3FF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000, 1'b1, 1,  "1/0"};
        vecs[4]  = '{64'h0000000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 1'b0, 1,  "0/0"};
        vecs[5]  = '{64'h8000000000000000, 64'h4014000000000000, 64'h8000000000000000, 1'b0, 1,  "-0/5"};
        vecs[6]  = '{64'h7FE0000000000000, 64'h3FD0000000000000, 64'h7FF0000000000000, 1'b0, 57, "overflow"};
        vecs[7]  = '{64'h3FF0000000000000, 64'h3FF4000000000000, 64'h3FE999999999999A, 1'b0, 57, "1/1.25 round up"};
        vecs[8]  = '{64'h7FF8000000000000, 64'h3FF0000000000000, 64'h7FF8000000000000, 1'b0, 1,  "NaN/1"};
        vecs[9]  = '{64'h0010000000000000, 64'h7FE0000000000000, 64'h0000000000000000, 1'b0, 57, "underflow"};
        vecs[10] = '{64'hBFF0000000000000, 64'h0000000000000000, 64'hFFF0000000000000, 1'b1, 1,  "-1/0"};
        vecs[11] = '{64'h3FF0000000000000, 64'h3FF0000000000001, 64'h3FEFFFFFFFFFFFFE, 1'b0, 57, "1/(1+ulp)"};

        rst = 1'b1;
        en = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset result", result, 64'd0);
        chk("reset div_by_zero", 64'(div_by_zero), 64'd0);

        for (int i = 0; i < 12; i++) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dbz, vecs[i].lat, 1'b0, -1, vecs[i].name);
        end

        // Reset pulsed while DIVIDE has cnt=20 aborts the running operation.
        @(negedge clk);
        A = 64'h4018000000000000;
        B = 64'h4000000000000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort result", result, 64'd0);
        chk("abort div_by_zero", 64'(div_by_zero), 64'd0);
        dones = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        chk("abort no late done", 64'(dones), 64'd0);

        // start held high with changing operands during the operation
        run_div(64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 1'b0, 57, 1'b1, -1, "start held");

        // ten frozen cycles mid-DIVIDE push done from edge 57 to 67
        run_div(64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 1'b0, 67, 1'b0, 20, "en freeze");

        // done pulse stretches while en=0, then falls on the next enabled edge
        run_div(64'h3FF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000, 1'b1, 1, 1'b0, -1, "1/0 again");
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("frozen done held", 64'(done), 64'd1);
        chk("frozen result held", result, 64'h7FF0000000000000);
        en = 1'b1;
        @(posedge clk);
        #1;
        chk("done falls", 64'(done), 64'd0);
        chk("result held after done", result, 64'h7FF0000000000000);
        chk("dbz held after done", 64'(div_by_zero), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
